// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
//
// Bit-plane decoder. A 16-bit presence mask and a packed payload are
// accepted together. Each mask bit names one bit-plane: bit i of eight
// consecutive bytes, either bytes 0..7 (mask bits 15..8) or bytes 8..15
// (mask bits 7..0). Present planes are stored back to back in the payload,
// starting at bit 127 and working downward. Absent planes decode to zero.
// The FSM handles one mask bit per cycle, from bit 15 down to bit 0, and
// then holds the 128-bit result until the consumer takes it.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   mask/encoded pair is presented
//   in_ready   out  decoder can accept a pair (IDLE only)
//   mask       in   [15:0] plane presence mask
//   encoded    in   [MEM_BW-1:0] packed planes, left-aligned at bit 127
//   out_valid  out  decoded is valid (DONE)
//   out_ready  in   consumer accepts decoded
//   decoded    out  [127:0] reconstructed word, byte 0 in bits 127:120
//   busy       out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module decoder #(
  parameter int MEM_BW = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       mask,
  input  logic [MEM_BW-1:0] encoded,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      decoded,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [15:0]         mask_reg;
  logic [MEM_BW-1:0]   enc_reg;
  logic [127:0]        acc_reg, acc_next;
  logic [3:0]          plane_reg;
  logic [6:0]          ptr_reg;

  logic                accept;
  logic                plane_present;
  logic [7:0]          plane_bits;
  logic [6:0]          acc_idx [8];

  assign accept        = in_valid && in_ready;
  assign plane_present = mask_reg[plane_reg];

  // Payload bit j of the current plane sits at ptr - j. The pointer only
  // reaches a present plane with at least 8 bits left above bit 0, so the
  // subtraction cannot underflow.
  //
  // Destination of plane bit j: byte b = 8k + j, bit i, which lands at
  // decoded[(15 - b)*8 + i]. With k = ~plane[3] and i = plane[2:0], the
  // index is simply {plane[3], 7 - j, plane[2:0]}.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_plane_bit
      assign plane_bits[gi] = enc_reg[ptr_reg - 7'(gi)];
      assign acc_idx[gi]    = {plane_reg[3], 3'(7 - gi), plane_reg[2:0]};
    end
  endgenerate

  // Absent planes need no action because the accumulator starts cleared.
  always_comb begin
    acc_next = acc_reg;
    if (plane_present) begin
      for (int j = 0; j < 8; j++) begin
        acc_next[acc_idx[j]] = plane_bits[j];
      end
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (mask != 16'd0) ? DECODE : DONE;
        end
      end
      DECODE: begin
        if (plane_reg == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign decoded = acc_reg;

  // ---------------- Datapath ----------------
  // In DECODE and DONE the inputs are not sampled, so upstream may change
  // them freely. The pointer is not stepped after plane 0, which keeps it
  // from wrapping past bit 0 when all 16 planes are present.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg  <= '0;
      enc_reg   <= '0;
      acc_reg   <= '0;
      plane_reg <= 4'd15;
      ptr_reg   <= 7'd127;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mask_reg  <= mask;
            enc_reg   <= encoded;
            acc_reg   <= '0;
            plane_reg <= 4'd15;
            ptr_reg   <= 7'd127;
          end
        end
        DECODE: begin
          acc_reg <= acc_next;
          if (plane_reg != 4'd0) begin
            plane_reg <= plane_reg - 4'd1;
            if (plane_present) begin
              ptr_reg <= ptr_reg - 7'd8;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder
//
// Directed and round-trip bench for the bit-plane decoder. The expected words
// come from a byte/bit plane model of the format and from a matching encoder
// model. A compare process checks decoded against the head of the expected
// queue on every cycle that out_valid is high.
// ---------------------------------------------------------------------------
module tb_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  mask;
  logic [127:0] encoded;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] decoded;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  decoder #(.MEM_BW(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mask      (mask),
    .encoded   (encoded),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .decoded   (decoded),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Plane m covers bit (m mod 8) of bytes 0..7 (m >= 8) or bytes 8..15.
  // Byte b occupies word bits (15-b)*8 +: 8.
  function automatic logic [127:0] model_decode(input logic [15:0] m, input logic [127:0] e);
    logic [127:0] r;
    int p;
    int byte0;
    int bit_i;
    r = '0;
    p = 127;
    for (int pl = 15; pl >= 0; pl--) begin
      byte0 = (pl >= 8) ? 0 : 8;
      bit_i = pl % 8;
      if (m[pl]) begin
        for (int j = 0; j < 8; j++) begin
          r[(15 - (byte0 + j)) * 8 + bit_i] = e[p - j];
        end
        p = p - 8;
      end
    end
    return r;
  endfunction

  // Reference encoder: a plane is emitted only when it holds a nonzero bit.
  function automatic void model_encode(input logic [127:0] w, output logic [15:0] m,
                                       output logic [127:0] e);
    logic [7:0] b;
    int p;
    int byte0;
    int bit_i;
    m = '0;
    e = '0;
    p = 127;
    for (int pl = 15; pl >= 0; pl--) begin
      byte0 = (pl >= 8) ? 0 : 8;
      bit_i = pl % 8;
      for (int j = 0; j < 8; j++) b[j] = w[(15 - (byte0 + j)) * 8 + bit_i];
      if (b != 8'd0) begin
        m[pl] = 1'b1;
        for (int j = 0; j < 8; j++) e[p - j] = b[j];
        p = p - 8;
      end
    end
  endfunction

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("ready_vs_busy", 128'(in_ready), 128'(!busy));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 decoded=%h expected no output", decoded);
        end else begin
          chk("decoded", decoded, exp_q[0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0 && out_valid && out_ready && exp_q.size() > 0) begin
      $display("txn %0d decoded=%h", txn, decoded);
      txn++;
      void'(exp_q.pop_front());
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Offer one pair, check latency, hold in DONE for 'hold' cycles, then pop.
  task automatic send(input logic [15:0] m, input logic [127:0] e,
                      input logic [127:0] exp, input int hold);
    int lat;
    logic [127:0] snap;
    wait_ready();
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
      return;
    end
    in_valid = 1'b1;
    mask     = m;
    encoded  = e;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom);
      mask     = 16'($urandom);
      encoded  = rand128();
      @(negedge clk);
      lat++;
    end
    if (m == 16'd0) chk("latency_zero_mask", 128'(lat <= 1), 128'(1));
    else            chk("latency", 128'(lat), 128'(16));
    if (!out_valid) begin
      exp_q.delete();
      in_valid = 1'b0;
      return;
    end
    snap = decoded;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      encoded  = rand128();
      @(negedge clk);
      chk("hold_decoded", decoded, snap);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      chk("hold_out_valid", 128'(out_valid), 128'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_pop", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [15:0]  em;
    logic [127:0] ee;
    logic [127:0] w;
    int n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mask      = '0;
    encoded   = '0;

    // Model pinned against hand-computed words.
    chk("model_8000", model_decode(16'h8000, {8'hFF, 120'h0}),
        128'h8080808080808080_0000000000000000);
    chk("model_0001", model_decode(16'h0001, {8'h81, 120'h0}),
        128'h0000000000000000_0100000000000001);
    chk("model_0000", model_decode(16'h0000, {128{1'b1}}), 128'h0);
    w = 128'h0123456789ABCDEF_FEDCBA9876543210;
    model_encode(w, em, ee);
    chk("model_roundtrip", model_decode(em, ee), w);

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_decoded", decoded, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 128'(in_ready), 128'(1));

    // Directed vectors with literal expectations.
    send(16'h0000, {128{1'b1}}, 128'h0, 3);
    send(16'h8000, {8'hFF, 120'(rand128())}, 128'h8080808080808080_0000000000000000, 2);
    send(16'h0001, {8'h81, 120'(rand128())}, 128'h0000000000000000_0100000000000001, 0);

    // Long stall in DONE.
    ee = rand128();
    send(16'hA5C3, ee, model_decode(16'hA5C3, ee), 20);

    // All planes present, random payloads.
    for (int t = 0; t < 20; t++) begin
      ee = rand128();
      send(16'hFFFF, ee, model_decode(16'hFFFF, ee), t % 3);
    end

    // Reset in the middle of DECODE discards the pair.
    wait_ready();
    in_valid = 1'b1;
    mask     = 16'hFFFF;
    encoded  = rand128();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_decode_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_out_valid", 128'(out_valid), 128'(0));
    chk("mid_reset_decoded", decoded, 128'h0);
    chk("mid_reset_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_output_after_reset", 128'(busy), 128'(0));
    ee = rand128();
    send(16'h3C5A, ee, model_decode(16'h3C5A, ee), 1);

    // Reset wins over out_ready in DONE.
    wait_ready();
    ee = rand128();
    in_valid = 1'b1;
    mask     = 16'h1234;
    encoded  = ee;
    exp_q.push_back(model_decode(16'h1234, ee));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    chk("done_reset_out_valid", 128'(out_valid), 128'(0));
    chk("done_reset_decoded", decoded, 128'h0);
    chk("done_reset_txn_dropped", 128'(exp_q.size()), 128'(1));
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    // Round trip through the reference encoder, sparse and dense words.
    for (int t = 0; t < 150; t++) begin
      case (t % 3)
        0:       w = rand128();
        1:       w = rand128() & rand128() & rand128();
        default: w = rand128() & rand128() & rand128() & rand128() & rand128();
      endcase
      model_encode(w, em, ee);
      send(em, ee, w, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter MEM_BW, default 128: width of the packed payload and the reconstructed word; only 128 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  mask/encoded pair is presented.
REQ-005 in_ready  output  1  decoder can accept a pair.
REQ-006 mask  input  16  bit-plane presence mask; bit m set means plane m is present in encoded.
REQ-007 encoded  input  MEM_BW  packed planes, left-aligned from bit 127 downward.
REQ-008 out_valid  output  1  decoded is valid.
REQ-009 out_ready  input  1  consumer accepts decoded.
REQ-010 decoded  output  128  reconstructed 16-byte word.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Byte b (0..15) of decoded SHALL be decoded[(15-b)*8 +: 8]; byte 0 is the most significant byte.
REQ-013 Mask bit m maps to a group and a bit: group k = 0 for m = 15..8 and k = 1 for m = 7..0; bit i = m mod 8; the plane covers bit i of bytes 8k..8k+7.
REQ-014 Planes SHALL be consumed in the order m = 15 down to 0, with a payload pointer starting at 127.
REQ-015 For each set mask bit: bit i of byte (8k+j) = encoded[ptr-j], for j = 0..7; then ptr decrements by 8.
REQ-016 For each clear mask bit: the covered bits SHALL be 0 and ptr SHALL be unchanged.
REQ-017 Payload bits below the final ptr SHALL be ignored.
REQ-018 FSM states: IDLE, DECODE, DONE.
REQ-019 IDLE: in_ready = 1.
REQ-020 IDLE, on in_valid & in_ready: register mask and encoded, clear the decoded accumulator, set plane index to 15 and ptr to 127.
REQ-021 IDLE, on that same handshake: go to DECODE if mask != 0, else go directly to DONE.
REQ-022 DECODE: process exactly one mask bit per cycle.
REQ-023 DECODE: after plane index 0 has been processed, go to DONE.
REQ-024 DONE: out_valid = 1, and decoded is held stable until out_ready.
REQ-025 DONE, on out_ready: go to IDLE on the next edge.
REQ-026 in_ready SHALL be 0 in DECODE and DONE; inputs changing there SHALL have no effect.
REQ-027 Latency: handshake at edge T, mask != 0 -> out_valid first high in the cycle after edge T+16 (17 cycles).
REQ-028 Latency: handshake at edge T, mask == 0 -> out_valid high after edge T+1, with decoded = 0.
REQ-029 The arithmetic on ptr is 7-bit and SHALL never wrap: 16 planes of 8 bits fill exactly 128 bits.
REQ-030 out_valid held with out_ready low SHALL stall indefinitely with no change to decoded.
REQ-031 The decoder SHALL be the exact inverse of the upstream bit-plane encoder for all 2^128 input words.

Reset
REQ-032 When rst = 1 at a clock edge: state becomes IDLE, out_valid = 0, busy = 0, decoded = 0, ptr = 127, plane index = 15.
REQ-033 Reset SHALL take priority over all other events, including mid-DECODE and in DONE while out_ready is high.
REQ-034 A pair being processed when reset occurs is discarded, and no out_valid follows it.
REQ-035 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-036 mask = 16'h0000, encoded = all ones -> out_valid after 1 cycle, decoded = 0.
REQ-037 mask = 16'h8000, encoded[127:120] = 8'hFF -> bit 7 of bytes 0..7 set; decoded = 128'h8080808080808080_0000000000000000; out_valid at cycle 17.
REQ-038 mask = 16'h0001, encoded[127:120] = 8'b10000001 -> bit 0 of byte 8 and of byte 15 set; decoded = 128'h0000000000000000_0100000000000001.
REQ-039 mask = 16'hFFFF, encoded = random R -> decoded = R re-laid per REQ-015; a round trip through the reference encoder model gives back the original word, over 10k random words.
REQ-040 Hold out_ready = 0 for 20 cycles in DONE -> decoded stable and in_ready = 0; then pulse out_ready -> in_ready = 1 on the next cycle.
REQ-041 Assert rst at DECODE cycle 8 -> next cycle: IDLE, out_valid = 0, decoded = 0; a new pair then decodes correctly.
